// File: rtl/hamming_stream_acc.sv
// Streaming Hamming distance / similarity accumulator.
// Takes a burst of word pairs over valid/ready and reports the total with a threshold-match flag.
module hamming_stream_acc #(
  parameter int N     = 8,
  parameter int LEN_W = 8,
  localparam int SUM_W = LEN_W + $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic [SUM_W-1:0] threshold,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in1,
  input  logic [N-1:0]     in2,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] total,
  output logic             match
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] thr_q;
  logic [LEN_W-1:0] remaining;
  logic             mode_q;
  logic             xfer;
  logic [CW-1:0]    pc;
  logic [CW-1:0]    contrib;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign xfer     = in_valid & in_ready;
  assign pc       = popcnt(in1 ^ in2);
  assign contrib  = mode_q ? (CW'(N) - pc) : pc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len != '0) ? RUN : DONE;
      RUN: begin
        // abort wins over a transfer arriving in the same cycle
        if (abort) state_d = IDLE;
        else if (xfer && remaining == LEN_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc       <= '0;
      thr_q     <= '0;
      remaining <= '0;
      mode_q    <= 1'b0;
      total     <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            thr_q <= threshold;
            if (len != '0) begin
              remaining <= len;
              mode_q    <= mode;
            end
          end
        end
        RUN: begin
          if (!abort && xfer) begin
            acc       <= acc + SUM_W'(contrib);
            remaining <= remaining - LEN_W'(1);
          end
        end
        DONE: begin
          total <= acc;
          match <= (acc <= thr_q);
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_stream_acc.sv
// Directed bench for hamming_stream_acc with a result scoreboard checked on each done pulse.
module tb_hamming_stream_acc;

  localparam int N     = 8;
  localparam int LEN_W = 8;
  localparam int SUM_W = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             mode;
  logic [SUM_W-1:0] threshold;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in1, in2;
  logic             busy, done;
  logic [SUM_W-1:0] total;
  logic             match;

  typedef struct {
    logic [SUM_W-1:0] t;
    logic             m;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   xfer_cyc = 0;
  int   done_cnt = 0;
  bit   chk_lat = 0;
  bit   ready_seen = 0;

  hamming_stream_acc #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode),
    .threshold(threshold), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .total(total), .match(match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (in_ready) ready_seen = 1;
    if (done) begin
      done_cnt++;
      check("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("total", 32'(total), 32'(e.t));
        check("match", 32'(match), 32'(e.m));
        if (chk_lat) check("done_latency", 32'(cyc - xfer_cyc), 32'd2);
      end
    end
  end

  task automatic push(input int t, input bit m);
    exp_t e;
    e.t = SUM_W'(t);
    e.m = m;
    sb.push_back(e);
  endtask

  task automatic start_burst(input int l, input bit m, input int thr);
    start = 1; len = LEN_W'(l); mode = m; threshold = SUM_W'(thr);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic xfer(input logic [7:0] a, input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1; in1 = a; in2 = b;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
    end
    check("xfer_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    xfer_cyc = cyc - 1;
    in_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt >= target), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic std_pairs(input int gap);
    xfer(8'hFF, 8'h00, gap);
    xfer(8'hAA, 8'h55, gap);
    xfer(8'h0F, 8'h0F, gap);
  endtask

  initial begin
    reset = 1; start = 0; len = '0; mode = 0; threshold = '0; abort = 0;
    in_valid = 0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    @(posedge clk); #1;
    reset = 0;

    // reset mid-burst
    start_burst(4, 0, 100);
    xfer(8'hFF, 8'h00, 0);
    xfer(8'hF0, 8'h00, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_total", 32'(total), 32'd0);
    check("midrst_match", 32'(match), 32'd0);
    @(posedge clk); #1;
    chk_lat = 1;
    push(1, 0);
    start_burst(1, 0, 0);
    xfer(8'h01, 8'h00, 0);
    wait_done(1);

    // distance / similarity with threshold edges
    push(16, 1); start_burst(3, 0, 16); std_pairs(0); wait_done(2);
    push(16, 0); start_burst(3, 0, 15); std_pairs(0); wait_done(3);
    push(8, 1);  start_burst(3, 1, 16); std_pairs(0); wait_done(4);
    push(16, 1); start_burst(3, 0, 16); std_pairs(3); wait_done(5);
    check("hold_total", 32'(total), 32'd16);
    check("done_low", 32'(done), 32'd0);

    // zero-length burst
    chk_lat = 0;
    ready_seen = 0;
    push(0, 1); start_burst(0, 0, 0); wait_done(6);
    check("len0_ready", 32'(ready_seen), 32'd0);

    // abort on the third pair
    chk_lat = 1;
    start_burst(4, 0, 100);
    xfer(8'hFF, 8'h00, 0);
    xfer(8'hFF, 8'h00, 0);
    in_valid = 1; in1 = 8'hFF; in2 = 8'h00; abort = 1;
    @(posedge clk); #1;
    abort = 0; in_valid = 0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_total", 32'(total), 32'd0);
    check("abort_match", 32'(match), 32'd1);
    check("abort_nodone", 32'(done_cnt), 32'd6);
    @(posedge clk); #1;

    // start pulsed mid-burst is ignored
    push(12, 1);
    start_burst(2, 0, 12);
    xfer(8'hFF, 8'h00, 0);
    start = 1; len = '0; mode = 1; threshold = '0;
    @(posedge clk); #1;
    start = 0;
    xfer(8'hF0, 8'h00, 0);
    wait_done(7);

    // longest burst, no wrap
    push(255 * 8, 0);
    start_burst(255, 0, 2039);
    for (int i = 0; i < 255; i++) xfer(8'hFF, 8'h00, 0);
    wait_done(8);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
